// File: rtl/rom_nibble_streamer.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// rom_nibble_streamer
//
// Host-side program loader for the tinysoc ROM-load bus. Holds a program
// image of 2**ADDR_W 16-bit words. On start it pulses the target reset for
// RST_CYCLES cycles, then streams the image one nibble per clock, four
// nibbles per word, least-significant nibble first, word 0 first.
//
// Parameters:
//   ADDR_W      image address width (image holds 2**ADDR_W words)
//   RST_CYCLES  cycles tgt_rst is held high before streaming (1..15)
//
// Ports:
//   clk         system clock, shared with the target
//   rst_n       synchronous active-low reset (also clears the image)
//   wr_en       image write strobe, honoured only while not busy
//   wr_addr     image word address
//   wr_data     image word
//   start       single-cycle load request, ignored while busy
//   tgt_rst     active-high reset to the target (io_in[1])
//   tgt_nibble  nibble to the target (io_in[7:4])
//   busy        load sequence in progress
//   done        sticky completion flag, cleared by the next accepted start
//   checksum    mod-16 sum of all streamed nibbles
//               (only when ROM_STREAMER_CHECKSUM_EN is defined)
// ----------------------------------------------------------------------------
module rom_nibble_streamer #(
   parameter int ADDR_W     = 3,
   parameter int RST_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [15:0]       wr_data,
   input  logic              start,
   output logic              tgt_rst,
   output logic [3:0]        tgt_nibble,
   output logic              busy,
   output logic              done
`ifdef ROM_STREAMER_CHECKSUM_EN
   ,
   output logic [3:0]        checksum
`endif
);

   localparam int DEPTH = 2**ADDR_W;
   localparam int POS_W = ADDR_W + 2;
   localparam logic [3:0]       RST_LOAD = 4'(RST_CYCLES - 1);
   localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

   typedef enum logic [1:0] {
      IDLE,
      RESET,
      STREAM,
      DONE
   } state_t;

   state_t           state, state_d;
   logic [3:0]       rst_cnt, rst_cnt_d;
   logic [POS_W-1:0] pos, pos_d;
   logic             tgt_rst_d;
   logic [3:0]       nibble_d;
   logic             busy_d;
   logic             done_d;

   logic [15:0]      image [DEPTH];
   logic [15:0]      cur_word;
   logic [3:0]       cur_nibble;

   // Position counter is {word_idx, nib_idx}; nib_idx picks the nibble lane.
   assign cur_word   = image[pos[POS_W-1:2]];
   assign cur_nibble = cur_word[{pos[1:0], 2'b00} +: 4];

   // Image storage. Writes are locked out while a load is running so the
   // stream always reflects the image as it was when start was accepted
   // (a write in the same cycle as start still lands, since busy is low).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            image[i] <= '0;
         end
      end else if (wr_en && !busy) begin
         image[wr_addr] <= wr_data;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         rst_cnt    <= '0;
         pos        <= '0;
         tgt_rst    <= 1'b1;
         tgt_nibble <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_d;
         rst_cnt    <= rst_cnt_d;
         pos        <= pos_d;
         tgt_rst    <= tgt_rst_d;
         tgt_nibble <= nibble_d;
         busy       <= busy_d;
         done       <= done_d;
      end
   end

   // Next-state and next-output logic. Entering STREAM already drives
   // nibble 0 and points the counter at nibble 1, so the counter wrapping
   // back to zero means the last nibble has just had its cycle on the bus.
   always_comb begin
      state_d   = state;
      rst_cnt_d = rst_cnt;
      pos_d     = pos;
      tgt_rst_d = tgt_rst;
      nibble_d  = tgt_nibble;
      busy_d    = busy;
      done_d    = done;

      case (state)
         IDLE: begin
            if (start) begin
               state_d   = RESET;
               busy_d    = 1'b1;
               done_d    = 1'b0;
               tgt_rst_d = 1'b1;
               rst_cnt_d = RST_LOAD;
            end
         end

         RESET: begin
            if (rst_cnt == 4'd0) begin
               state_d   = STREAM;
               tgt_rst_d = 1'b0;
               nibble_d  = image[0][3:0];
               pos_d     = POS_ONE;
            end else begin
               rst_cnt_d = rst_cnt - 4'd1;
            end
         end

         STREAM: begin
            if (pos == '0) begin
               state_d  = DONE;
               nibble_d = 4'd0;
            end else begin
               nibble_d = cur_nibble;
               pos_d    = pos + POS_ONE;
            end
         end

         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

`ifdef ROM_STREAMER_CHECKSUM_EN
   logic [3:0] checksum_d;

   // Every STREAM edge sees exactly one streamed nibble on tgt_nibble
   // (nibble 0 on the first, the last nibble on the wrap edge).
   always_comb begin
      checksum_d = checksum;
      if (state == IDLE && start) begin
         checksum_d = 4'd0;
      end else if (state == STREAM) begin
         checksum_d = checksum + tgt_nibble;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         checksum <= '0;
      end else begin
         checksum <= checksum_d;
      end
   end
`endif

endmodule

// File: doc/rom_nibble_streamer.md
# rom_nibble_streamer

Host-side program loader that drives the tinysoc ROM-load bus. It holds a 16-bit-word program image and, on `start`, pulses the target's active-high reset. It then streams the image one nibble per clock onto the target's `io_in[7:4]` pins: four nibbles per word, least-significant first, word 0 first. It sits outside the SoC on the same clock and is the transmitting end of the nibble loader inside tinysoc.

## Interface
- `ADDR_W`, default 3: image address width; image holds 2**ADDR_W words (8 by default, matching the SoC instruction memory).
- `RST_CYCLES`, default 2: number of cycles `tgt_rst` is held high before streaming; legal range 1..15.
- `clk`  in  1  system clock; the same clock drives the target `io_in[0]`.
- `rst_n`  in  1  synchronous, active-low reset.
- `wr_en`  in  1  image write strobe.
- `wr_addr`  in  ADDR_W  image word address.
- `wr_data`  in  16  image word.
- `start`  in  1  single-cycle request to begin a load sequence.
- `tgt_rst`  out  1  active-high reset to the target (`io_in[1]`).
- `tgt_nibble`  out  4  nibble to the target (`io_in[7:4]`).
- `busy`  out  1  high from the cycle after an accepted `start` until the sequence ends.
- `done`  out  1  sticky: set when the last nibble has been driven, cleared by the next accepted `start`.

## Operation
- Clock and reset: one clock; reset is synchronous and active-low.
- All outputs are registered.
- Reset values:
  - `tgt_rst` = 1, so the target is held in reset until the first load.
  - `tgt_nibble` = 0, `busy` = 0, `done` = 0.
  - State returns to IDLE, image words cleared to 0.
- Image writes:
  - Accepted only when `busy` = 0. Writes while busy are dropped.
  - A write and a `start` in the same cycle: the write commits at that edge and the stream uses the new word.
- FSM states: IDLE, RESET, STREAM, DONE.
- IDLE:
  - `start` -> RESET, with `busy` set, `done` cleared, `tgt_rst` set, and the reset counter loaded with RST_CYCLES-1.
  - Otherwise remain in IDLE.
- RESET:
  - Count down with `tgt_rst` = 1.
  - At count 0 -> STREAM, with `tgt_rst` = 0 and `tgt_nibble` = word[0][3:0], both set at the same edge.
- STREAM:
  - 5-bit position counter `{word_idx, nib_idx}`, ADDR_W+2 bits wide.
  - `tgt_nibble` = word[word_idx][4*nib_idx+3 : 4*nib_idx].
  - The counter advances by 1 each cycle; the last nibble is word[2**ADDR_W-1][15:12].
  - After the last nibble is driven for one cycle -> DONE, with `tgt_nibble` = 0.
- DONE: `busy` = 0, `done` = 1, `tgt_rst` stays 0 (target runs) -> IDLE on the same edge.
- `start` while `busy`: ignored.
- `start` in IDLE after a completed load: re-resets the target and reloads the image.
- `rst_n` low mid-sequence: abort, all outputs return to reset values on that edge, and the image is cleared.

## Timing
- Let `start` be sampled at edge E.
  - `tgt_rst` = 1 during cycles E+1 .. E+RST_CYCLES.
  - Nibble k (k = 0..4*2**ADDR_W-1) is valid during cycle E+RST_CYCLES+1+k.
- Target alignment: the target's nibble counter is 0 on the first edge at which it samples `tgt_rst` = 0. Nibble 0 is therefore captured then, and every word lands 4 cycles later than the previous one.
- With defaults, the stream is 32 cycles. `done` rises at E+35 (E+RST_CYCLES+33) and `busy` falls at the same edge.
- Throughput: one nibble per cycle, no stalls, no handshake from the target.

## Configuration
- `ROM_STREAMER_CHECKSUM_EN` defined:
  - Adds output `checksum` (4 bits), the mod-16 sum of all streamed nibbles.
  - Accumulates during STREAM, cleared on accepted `start` and on reset.
  - Valid whenever `done` = 1.
- Macro undefined: the port and the accumulator are absent; all other behaviour is identical.

## Test plan
- Reset: hold `rst_n` = 0 for 3 cycles -> `tgt_rst` = 1, `tgt_nibble` = 0, `busy` = 0, `done` = 0.
- Basic stream:
  - Stimulus: write word[0] = 16'h6021, word[1] = 16'hA5C3, remaining words 0, then `start`.
  - Required: `tgt_rst` high for 2 cycles, then `tgt_nibble` sequence 1,2,0,6,3,C,5,A, then 24 zeros; `done` at E+35.
- End-to-end: drive a tinysoc instance from the outputs with an image of an ALU/IMM/store-to-0x8 program -> target ROM words match the image, and `gpo` shows the expected value.
- Ignored requests: write word[3] = 16'hFFFF and pulse `start` during STREAM -> stream unchanged and no restart; word[3] still holds its old value afterwards.
- Reset mid-stream: drop `rst_n` at nibble 10 -> same edge gives `tgt_rst` = 1 and `busy` = 0; a subsequent `start` streams 32 zero nibbles.
- Checksum (macro defined): image of all 16'h1111 -> `checksum` = 32 mod 16 = 0. Image word[0] = 16'h000F, others 0 -> `checksum` = 4'hF.
